xbar_output_allocator: RTL and testbench

- Allocates one router output port (and its crossbar column) among the five input ports L, N, E, W, S.
- A grant is locked from a header flit until the matching tail flit is forwarded.
- Arbitration is round-robin. Flit flow is gated by downstream credits, and a watchdog releases a stalled lock.
- One instance sits per output port, between the input buffers and the crossbar select lines.

---
 rtl/xbar_output_allocator_if.sv | 23 ++
 rtl/xbar_output_allocator.sv | 130 +++++++++++++
 tb/tb_xbar_output_allocator.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/xbar_output_allocator_if.sv
// Handshake bundle between the input-port side and one output-port allocator.
// The master drives requests and credit returns; the allocator drives grant/status.
interface xbar_output_allocator_if;
  logic [4:0]  req;
  logic [14:0] flit_id;
  logic        credit_in;
  logic [4:0]  grant;
  logic [2:0]  xbar_sel;
  logic        fwd;
  logic [3:0]  credits;
  logic        busy;
  logic        timeout_err;

  modport master (
    output req, flit_id, credit_in,
    input  grant, xbar_sel, fwd, credits, busy, timeout_err
  );

  modport slave (
    input  req, flit_id, credit_in,
    output grant, xbar_sel, fwd, credits, busy, timeout_err
  );
endinterface

// File: rtl/xbar_output_allocator.sv
// Per-output-port allocator: round-robin header arbitration, packet lock until tail,
// downstream credit accounting and a watchdog that force-releases a stalled lock.
module xbar_output_allocator #(
  parameter int unsigned CREDITS = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input logic                    clk,
  input logic                    rst,
  xbar_output_allocator_if.slave bus
);

  typedef enum logic {IDLE, LOCKED} state_t;

  localparam logic [3:0]  CRED_MAX = 4'(CREDITS);
  localparam logic [11:0] WD_LAST  = 12'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [4:0]  grant_q, grant_d;
  logic [2:0]  sel_q, sel_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [3:0]  cred_q, cred_d;
  logic [11:0] wd_q, wd_d;
  logic        tmo_q, tmo_d;

  logic [4:0]  cand;
  logic [4:0]  tail_vec;
  logic        found;
  logic [2:0]  win;
  logic        fwd;
  logic        tail_fwd;
  int unsigned idx;

  always_comb begin
    cand     = '0;
    tail_vec = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      cand[i]     = bus.req[i] & bus.flit_id[3*i];
      tail_vec[i] = bus.flit_id[3*i+2];
    end
  end

  // First candidate at or after the pointer, wrapping 4 -> 0
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < 5; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= 5) idx = idx - 5;
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = 3'(idx);
      end
    end
  end

  // grant_q is one-hot while locked, so masking selects the owner's signals
  assign fwd      = (state_q == LOCKED) && ((bus.req & grant_q) != '0) && (cred_q != '0);
  assign tail_fwd = fwd && ((tail_vec & grant_q) != '0);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    wd_d    = wd_q;
    tmo_d   = 1'b0;
    case (state_q)
      IDLE: begin
        wd_d = '0;
        if (found) begin
          state_d = LOCKED;
          grant_d = 5'b00001 << win;
          sel_d   = win;
        end
      end
      LOCKED: begin
        if (tail_fwd || (!fwd && wd_q == WD_LAST)) begin
          state_d = IDLE;
          grant_d = '0;
          sel_d   = 3'd7;
          ptr_d   = (sel_q == 3'd4) ? 3'd0 : sel_q + 3'd1;
          wd_d    = '0;
          tmo_d   = !tail_fwd;
        end else if (fwd) begin
          wd_d = '0;
        end else begin
          wd_d = wd_q + 12'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cred_d = cred_q;
    if (fwd && !bus.credit_in)
      cred_d = cred_q - 4'd1;
    else if (bus.credit_in && !fwd && cred_q != CRED_MAX)
      cred_d = cred_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= 3'd7;
      ptr_q   <= '0;
      cred_q  <= CRED_MAX;
      wd_q    <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cred_q  <= cred_d;
      wd_q    <= wd_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.xbar_sel    = sel_q;
  assign bus.fwd         = fwd;
  assign bus.credits     = cred_q;
  assign bus.busy        = (state_q == LOCKED);
  assign bus.timeout_err = tmo_q;

endmodule

// File: tb/tb_xbar_output_allocator.sv
// Bench for xbar_output_allocator: packet-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_xbar_output_allocator;
  localparam int CRED = 2;
  localparam int TMO  = 8;

  logic clk = 1'b0;
  logic rst;
  xbar_output_allocator_if bus ();

  xbar_output_allocator #(.CREDITS(CRED), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_locked  = 0;
  int m_owner   = 0;
  int m_ptr     = 0;
  int m_cred    = CRED;
  int m_stall   = 0;
  bit m_tmo     = 0;
  bit started   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_fwd();
    return m_locked && bus.req[m_owner] && (m_cred > 0);
  endfunction

  always @(posedge clk) begin
    bit f;
    int best, bestd, d;
    started = 1;
    if (rst) begin
      m_locked = 0; m_owner = 0; m_ptr = 0; m_cred = CRED; m_stall = 0; m_tmo = 0;
    end else begin
      f = m_fwd();
      if (f && !bus.credit_in) m_cred--;
      else if (bus.credit_in && !f && m_cred < CRED) m_cred++;
      m_tmo = 0;
      if (!m_locked) begin
        best = -1; bestd = 99;
        for (int i = 0; i < 5; i++) begin
          d = (i - m_ptr + 5) % 5;
          if (bus.req[i] && bus.flit_id[3*i] && d < bestd) begin
            best = i; bestd = d;
          end
        end
        if (best >= 0) begin
          m_locked = 1; m_owner = best; m_stall = 0;
        end
      end else if (f && bus.flit_id[3*m_owner+2]) begin
        m_locked = 0; m_ptr = (m_owner + 1) % 5;
      end else if (f) begin
        m_stall = 0;
      end else begin
        m_stall++;
        if (m_stall == TMO) begin
          m_locked = 0; m_ptr = (m_owner + 1) % 5; m_tmo = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("grant",       32'(bus.grant),       m_locked ? (32'd1 << m_owner) : 32'd0);
      check("xbar_sel",    32'(bus.xbar_sel),    m_locked ? 32'(m_owner) : 32'd7);
      check("busy",        32'(bus.busy),        32'(m_locked));
      check("credits",     32'(bus.credits),     32'(m_cred));
      check("timeout_err", 32'(bus.timeout_err), 32'(m_tmo));
      check("fwd",         32'(bus.fwd),         32'(m_fwd()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fid(input int i, input logic [2:0] v);
    bus.flit_id[3*i +: 3] = v;
  endtask

  int cnt;

  initial begin
    rst = 1'b1;
    bus.req = '0; bus.flit_id = '0; bus.credit_in = 1'b0;
    tick(); tick();
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_sel",   32'(bus.xbar_sel), 32'd7);
    check("rst_cred",  32'(bus.credits), 32'd2);
    check("rst_busy",  32'(bus.busy), 32'd0);
    rst = 1'b0;

    // Round-robin L -> E -> S -> L with credits kept topped up
    bus.req = 5'b10101; bus.flit_id = 15'b001001001001001; bus.credit_in = 1'b1;
    tick();
    check("rr_L", 32'(bus.grant), 32'b00001);
    set_fid(0, 3'b010); tick();
    set_fid(0, 3'b100); tick();
    check("rr_gap", 32'(bus.grant), 32'd0);
    set_fid(0, 3'b001); tick();
    check("rr_E", 32'(bus.grant), 32'b00100);
    set_fid(2, 3'b100); tick();
    set_fid(2, 3'b001); tick();
    check("rr_S", 32'(bus.grant), 32'b10000);
    set_fid(4, 3'b100); tick();
    set_fid(4, 3'b001); tick();
    check("rr_wrap_L", 32'(bus.grant), 32'b00001);
    set_fid(0, 3'b101); tick();
    bus.req = '0; bus.credit_in = 1'b0; tick();

    // Credit exhaustion on a 4-flit N packet
    bus.flit_id = '0; bus.req = 5'b00010; set_fid(1, 3'b001);
    tick();
    check("n_grant", 32'(bus.grant), 32'b00010);
    check("n_fwd_hdr", 32'(bus.fwd), 32'd1);
    tick();
    set_fid(1, 3'b010);
    check("n_cred1", 32'(bus.credits), 32'd1);
    tick();
    #1;
    check("n_cred0", 32'(bus.credits), 32'd0);
    check("n_stall", 32'(bus.fwd), 32'd0);
    tick();
    bus.credit_in = 1'b1; tick(); bus.credit_in = 1'b0; #1;
    check("n_cred_ret", 32'(bus.credits), 32'd1);
    check("n_resume", 32'(bus.fwd), 32'd1);
    tick();
    set_fid(1, 3'b100);
    bus.credit_in = 1'b1; tick();
    check("n_cred_back", 32'(bus.credits), 32'd1);
    tick();
    check("n_both_same", 32'(bus.credits), 32'd1);
    check("n_released", 32'(bus.grant), 32'd0);
    bus.req = '0;
    tick(); tick();
    check("cred_sat", 32'(bus.credits), 32'd2);
    bus.credit_in = 1'b0;

    // Watchdog on W after one forwarded flit
    bus.flit_id = '0; bus.req = 5'b01000; set_fid(3, 3'b001);
    tick();
    check("w_grant", 32'(bus.grant), 32'b01000);
    tick();
    bus.req = '0;
    cnt = 0;
    while (bus.grant != '0 && cnt < 20) begin
      tick(); cnt++;
    end
    check("wd_cycles", 32'(cnt), 32'd8);
    check("wd_err", 32'(bus.timeout_err), 32'd1);
    bus.credit_in = 1'b1;
    bus.req = 5'b11111; bus.flit_id = 15'b001001001001001;
    tick();
    check("wd_err_pulse", 32'(bus.timeout_err), 32'd0);
    check("wd_ptr_S", 32'(bus.grant), 32'b10000);
    bus.credit_in = 1'b0;

    // Reset in the middle of S's packet
    set_fid(4, 3'b010); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_rst_grant", 32'(bus.grant), 32'd0);
    check("mid_rst_sel", 32'(bus.xbar_sel), 32'd7);
    check("mid_rst_cred", 32'(bus.credits), 32'd2);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);

    // Body flit without header must not be granted
    bus.req = 5'b00010; bus.flit_id = '0; set_fid(1, 3'b010);
    tick(); tick();
    check("body_ignored", 32'(bus.grant), 32'd0);

    // Single-flit packet from E
    bus.flit_id = '0; bus.req = 5'b00100; set_fid(2, 3'b101);
    tick();
    check("sf_grant", 32'(bus.grant), 32'b00100);
    check("sf_fwd", 32'(bus.fwd), 32'd1);
    tick();
    bus.req = '0;
    check("sf_release", 32'(bus.grant), 32'd0);
    check("sf_cred", 32'(bus.credits), 32'd1);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
